// File: rtl/pkt_tx_seq.sv
`default_nettype none
// ============================================================================
// Module   : pkt_tx_seq
// Purpose  : Frames raw AXI write beats into NoC flit requests (head/last,
//            size, VC) through one registered output stage.
//            Optional VC-mismatch drop/flag: define PKT_TX_SEQ_VC_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module pkt_tx_seq #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int NUM_VC          = 3,
    parameter int PKT_WIDTH       = 8,
    localparam int VC_W           = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                       clk_axi,
    input  logic                       rst_axi_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [FLIT_DATA_WIDTH-1:0] wr_data,
    input  logic [VC_W-1:0]            wr_vc,
    input  logic [PKT_WIDTH-1:0]       wr_pkt_sz,
    output logic                       pkt_out_valid,
    input  logic                       pkt_out_ready,
    output logic                       pkt_out_req_new,
    output logic                       pkt_out_req_last,
    output logic [FLIT_DATA_WIDTH-1:0] pkt_out_flit_data,
    output logic [PKT_WIDTH-1:0]       pkt_out_pkt_sz,
    output logic [VC_W-1:0]            pkt_out_vc_id,
    output logic                       busy,
    output logic                       seq_err
);

    localparam logic [PKT_WIDTH-1:0] c_PKT_ONE = {{(PKT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [PKT_WIDTH-1:0]       rem_q, rem_d;
    logic [VC_W-1:0]            lock_vc_q, lock_vc_d;
    logic [PKT_WIDTH-1:0]       lock_sz_q, lock_sz_d;
    logic                       vld_q, vld_d;
    logic                       new_q, new_d;
    logic                       last_q, last_d;
    logic [FLIT_DATA_WIDTH-1:0] data_q, data_d;
    logic [PKT_WIDTH-1:0]       sz_q, sz_d;
    logic [VC_W-1:0]            vc_q, vc_d;

    logic w_accept;
    logic w_xfer;
    logic w_drop;
    logic w_emit;

    assign wr_ready = !vld_q || pkt_out_ready;
    assign w_accept = wr_valid && wr_ready;
    assign w_xfer   = vld_q && pkt_out_ready;
    assign w_emit   = w_accept && !w_drop;

`ifdef PKT_TX_SEQ_VC_CHECK_EN
    logic err_q, err_d;

    // Off-VC body beats are consumed but produce no flit and leave the count alone.
    assign w_drop = w_accept && (state_q == ST_BODY) && (wr_vc != lock_vc_q);
    assign err_d  = err_q || w_drop;

    always_ff @(posedge clk_axi) begin
        if (!rst_axi_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign seq_err = err_q;
`else
    assign w_drop  = 1'b0;
    assign seq_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        lock_vc_d = lock_vc_q;
        lock_sz_d = lock_sz_q;
        vld_d     = vld_q;
        new_d     = new_q;
        last_d    = last_q;
        data_d    = data_q;
        sz_d      = sz_q;
        vc_d      = vc_q;

        if (w_xfer) begin
            vld_d = 1'b0;
        end

        if (w_emit) begin
            vld_d  = 1'b1;
            data_d = wr_data;
            case (state_q)
                ST_IDLE: begin
                    new_d     = 1'b1;
                    sz_d      = wr_pkt_sz;
                    vc_d      = wr_vc;
                    lock_sz_d = wr_pkt_sz;
                    lock_vc_d = wr_vc;
                    if (wr_pkt_sz == '0) begin
                        last_d = 1'b1;
                    end else begin
                        last_d  = 1'b0;
                        rem_d   = wr_pkt_sz;
                        state_d = ST_BODY;
                    end
                end
                default: begin
                    new_d = 1'b0;
                    vc_d  = lock_vc_q;
                    sz_d  = lock_sz_q;
                    rem_d = rem_q - c_PKT_ONE;
                    if (rem_q == c_PKT_ONE) begin
                        last_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        last_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_axi) begin
        if (!rst_axi_n) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            lock_vc_q <= '0;
            lock_sz_q <= '0;
            vld_q     <= 1'b0;
            new_q     <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            sz_q      <= '0;
            vc_q      <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            lock_vc_q <= lock_vc_d;
            lock_sz_q <= lock_sz_d;
            vld_q     <= vld_d;
            new_q     <= new_d;
            last_q    <= last_d;
            data_q    <= data_d;
            sz_q      <= sz_d;
            vc_q      <= vc_d;
        end
    end

    assign pkt_out_valid     = vld_q;
    assign pkt_out_req_new   = new_q;
    assign pkt_out_req_last  = last_q;
    assign pkt_out_flit_data = data_q;
    assign pkt_out_pkt_sz    = sz_q;
    assign pkt_out_vc_id     = vc_q;
    assign busy              = (state_q == ST_BODY);

endmodule
`default_nettype wire

// File: tb/tb_pkt_tx_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_tx_seq
// Purpose  : Randomized bench for pkt_tx_seq; expected flits come from a
//            packet-level beat list and a one-slot output model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pkt_tx_seq;

    localparam int c_DW   = 32;
    localparam int c_VCW  = 2;
    localparam int c_PW   = 8;
    localparam int c_BUDGET = 20000;
`ifdef PKT_TX_SEQ_VC_CHECK_EN
    localparam bit c_VCCHK = 1'b1;
`else
    localparam bit c_VCCHK = 1'b0;
`endif

    logic              clk_axi = 1'b0;
    logic              rst_axi_n;
    logic              wr_valid;
    logic              wr_ready;
    logic [c_DW-1:0]   wr_data;
    logic [c_VCW-1:0]  wr_vc;
    logic [c_PW-1:0]   wr_pkt_sz;
    logic              pkt_out_valid;
    logic              pkt_out_ready;
    logic              pkt_out_req_new;
    logic              pkt_out_req_last;
    logic [c_DW-1:0]   pkt_out_flit_data;
    logic [c_PW-1:0]   pkt_out_pkt_sz;
    logic [c_VCW-1:0]  pkt_out_vc_id;
    logic              busy;
    logic              seq_err;

    pkt_tx_seq #(.FLIT_DATA_WIDTH(c_DW), .NUM_VC(3), .PKT_WIDTH(c_PW)) u_dut (
        .clk_axi          (clk_axi),
        .rst_axi_n        (rst_axi_n),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_data          (wr_data),
        .wr_vc            (wr_vc),
        .wr_pkt_sz        (wr_pkt_sz),
        .pkt_out_valid    (pkt_out_valid),
        .pkt_out_ready    (pkt_out_ready),
        .pkt_out_req_new  (pkt_out_req_new),
        .pkt_out_req_last (pkt_out_req_last),
        .pkt_out_flit_data(pkt_out_flit_data),
        .pkt_out_pkt_sz   (pkt_out_pkt_sz),
        .pkt_out_vc_id    (pkt_out_vc_id),
        .busy             (busy),
        .seq_err          (seq_err)
    );

    always #5 clk_axi = ~clk_axi;

    // One entry per write beat: what to drive and what flit it should become.
    typedef struct packed {
        logic [c_DW-1:0]  d;
        logic [c_VCW-1:0] wvc;
        logic [c_PW-1:0]  wsz;
        logic             nw;
        logic             lst;
        logic [c_VCW-1:0] vc;
        logic [c_PW-1:0]  sz;
        logic             drop;
        logic             stall;
        logic             rsta;
    } beat_t;

    beat_t bq[$];
    beat_t mf;
    bit    mv, mbusy, merr, chk_rst, rst_req;
    int    stall_cnt, popped, n_dir;
    int    n_chk, n_pass;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic add_pkt(input int vc, input int sz, input int bad_pos, input bit stall,
                           input int rst_at, input logic [31:0] dbase, input bit inc);
        beat_t b;
        for (int i = 0; i <= sz; i++) begin
            b       = '0;
            b.d     = inc ? dbase + 32'(i) : $urandom;
            b.nw    = (i == 0);
            b.lst   = (i == sz);
            b.vc    = c_VCW'(vc);
            b.sz    = c_PW'(sz);
            b.stall = stall && (i == 0);
            b.rsta  = (i == rst_at);
            b.wsz   = (i == 0) ? c_PW'(sz) : c_PW'($urandom);
            b.wvc   = (i == 0 || c_VCCHK) ? c_VCW'(vc) : c_VCW'($urandom_range(0, 2));
            if (i == bad_pos) begin
                if (c_VCCHK) begin
                    beat_t x;
                    x      = b;
                    x.d    = $urandom;
                    x.wvc  = (vc == 0) ? 2'd1 : 2'd0;
                    x.drop = 1'b1;
                    x.rsta = 1'b0;
                    bq.push_back(x);
                end else begin
                    b.wvc = (vc == 0) ? 2'd1 : 2'd0;
                end
            end
            bq.push_back(b);
        end
    endtask

    task automatic model_step();
        beat_t b;
        bit acc, xfer;
        if (!rst_axi_n) begin
            mv = 0; mbusy = 0; merr = 0; chk_rst = 1;
            while (bq.size() > 0 && !bq[0].nw) begin
                void'(bq.pop_front());
                popped++;
            end
        end else begin
            acc  = wr_valid && (!mv || pkt_out_ready);
            xfer = mv && pkt_out_ready;
            if (xfer) mv = 0;
            if (acc && bq.size() > 0) begin
                b = bq.pop_front();
                popped++;
                if (b.stall) stall_cnt = 3;
                if (b.rsta) rst_req = 1;
                if (b.drop) merr = 1;
                else begin
                    mv = 1; mf = b; mbusy = !b.lst;
                end
            end
        end
    endtask

    task automatic drive();
        bit phase0;
        phase0 = (popped < n_dir);
        rst_axi_n = !rst_req;
        if (rst_req) begin
            rst_req  = 0;
            wr_valid = 1'b0;
        end else begin
            wr_valid = (bq.size() > 0) && (phase0 || $urandom_range(0, 3) != 0);
        end
        if (bq.size() > 0) begin
            wr_data = bq[0].d; wr_vc = bq[0].wvc; wr_pkt_sz = bq[0].wsz;
        end else begin
            wr_data = $urandom; wr_vc = c_VCW'($urandom_range(0, 2)); wr_pkt_sz = c_PW'($urandom);
        end
        if (stall_cnt > 0) begin
            pkt_out_ready = 1'b0;
            stall_cnt--;
        end else begin
            pkt_out_ready = phase0 ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic compare();
        if (chk_rst) begin
            chk_rst = 0;
            check_val("rst_valid", 32'(pkt_out_valid), 0);
            check_val("rst_new", 32'(pkt_out_req_new), 0);
            check_val("rst_last", 32'(pkt_out_req_last), 0);
            check_val("rst_data", pkt_out_flit_data, 0);
            check_val("rst_sz", 32'(pkt_out_pkt_sz), 0);
            check_val("rst_vc", 32'(pkt_out_vc_id), 0);
        end
        check_val("valid", 32'(pkt_out_valid), 32'(mv));
        check_val("wr_ready", 32'(wr_ready), 32'(!mv || pkt_out_ready));
        check_val("busy", 32'(busy), 32'(mbusy));
        check_val("seq_err", 32'(seq_err), 32'(merr));
        if (mv) begin
            check_val("data", pkt_out_flit_data, mf.d);
            check_val("new", 32'(pkt_out_req_new), 32'(mf.nw));
            check_val("last", 32'(pkt_out_req_last), 32'(mf.lst));
            check_val("vc_id", 32'(pkt_out_vc_id), 32'(mf.vc));
            check_val("pkt_sz", 32'(pkt_out_pkt_sz), 32'(mf.sz));
        end
    endtask

    initial begin
        int cyc;
        n_chk = 0; n_pass = 0; popped = 0; stall_cnt = 0;
        mv = 0; mbusy = 0; merr = 0; chk_rst = 0; mf = '0;
        add_pkt(2, 0, -1, 0, -1, 32'hA5A5_0001, 1);
        add_pkt(1, 3, -1, 0, -1, 32'h0000_0010, 1);
        add_pkt(0, 2, -1, 1, -1, 32'h0000_0200, 1);
        add_pkt(0, 1, -1, 0, -1, 32'h0000_0300, 1);
        add_pkt(2, 0, -1, 0, -1, 32'h0000_0400, 1);
        add_pkt(1, 5, -1, 0,  2, 32'h0000_0500, 1);
        add_pkt(1, 2,  1, 0, -1, 32'h0000_0600, 1);
        n_dir = bq.size();
        for (int p = 0; p < 40; p++) begin
            int sz;
            sz = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            add_pkt($urandom_range(0, 2), sz,
                    (sz > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(1, sz) : -1,
                    0, -1, 32'h0, 0);
            if (p == 20) add_pkt(2, 255, -1, 0, -1, 32'h0, 0);
        end
        rst_req = 1;
        drive();
        cyc = 0;
        while ((bq.size() > 0 || mv) && cyc < c_BUDGET) begin
            @(posedge clk_axi);
            model_step();
            #1;
            drive();
            @(negedge clk_axi);
            compare();
            cyc++;
        end
        check_val("drain_beats", 32'(bq.size()), 0);
        check_val("drain_valid", 32'(mv), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_tx_seq.md
Name: pkt_tx_seq

Overview:
- TX packet sequencer between the AXI slave write-data path and the NoC packet processor.
- Turns a stream of raw write beats (data + VC + packet length) into framed flit requests carrying new/last markers, packet size and VC id.
- Tracks the remaining flit count so that each packet gets exactly one head flit and one closing flit.
- Locks the VC for the duration of a packet.
- One registered output stage; full throughput under continuous ready.

Parameters:
- FLIT_DATA_WIDTH, 32, payload bits per flit (flit type bits excluded).
- NUM_VC, 3, number of virtual channels; VC_W = max(1, $clog2(NUM_VC)) is derived.
- PKT_WIDTH, 8, width of the packet-size field: number of flits following the head.

Ports:
- clk_axi  in  1  AXI-domain clock.
- rst_axi_n  in  1  synchronous active-low reset, sampled on rising clk_axi.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat ready.
- wr_data  in  FLIT_DATA_WIDTH  beat payload.
- wr_vc  in  VC_W  VC of the beat; sampled on head only.
- wr_pkt_sz  in  PKT_WIDTH  flits after the head; sampled on head only.
- pkt_out_valid  out  1  flit request valid.
- pkt_out_ready  in  1  downstream accepts flit.
- pkt_out_req_new  out  1  flit is head.
- pkt_out_req_last  out  1  flit closes the packet.
- pkt_out_flit_data  out  FLIT_DATA_WIDTH  payload.
- pkt_out_pkt_sz  out  PKT_WIDTH  size of the current packet; held for every flit of the packet.
- pkt_out_vc_id  out  VC_W  locked VC of the current packet.
- busy  out  1  a packet is in progress (state BODY).
- seq_err  out  1  sticky VC-mismatch flag; tied 0 when the optional feature is off.

Behaviour:
- Reset: all outputs 0, state IDLE, remaining counter 0, locked VC 0. Reset mid-packet abandons the packet and drops any registered flit; no tail is emitted.
- Handshakes: a beat is accepted when wr_valid && wr_ready; a flit is transferred when pkt_out_valid && pkt_out_ready.
- Output register:
  - wr_ready = !pkt_out_valid || pkt_out_ready.
  - An accepted beat appears on pkt_out_* the next cycle (latency 1).
  - Output fields hold stable while pkt_out_valid && !pkt_out_ready.
  - pkt_out_valid clears after transfer when no new beat is accepted.
  - wr_valid may deassert between beats; bubbles are allowed.
- State IDLE, on accepted beat (head):
  - Register req_new = 1; pkt_sz = wr_pkt_sz; vc_id = wr_vc; lock VC and size.
  - If wr_pkt_sz == 0: req_last = 1 as well, single-flit packet; stay IDLE.
  - Else: req_last = 0, remaining = wr_pkt_sz, go to BODY.
- State BODY, on accepted beat:
  - req_new = 0; vc_id = locked VC; pkt_sz = locked size; remaining decrements by 1.
  - If remaining == 1 before the decrement: req_last = 1, go to IDLE.
  - Else: req_last = 0, stay BODY.
  - wr_vc and wr_pkt_sz are ignored.
- Counter arithmetic: PKT_WIDTH-bit unsigned, never wraps; max packet = 2^PKT_WIDTH flits including head (sz = 255 gives 256 flits).
- Back-to-back packets: a head beat may be accepted in the same cycle the previous tail transfers downstream; no idle cycle is required.
- busy = (state == BODY).

Optional Feature:
- Macro: PKT_TX_SEQ_VC_CHECK_EN.
- Defined:
  - In BODY, a beat whose wr_vc != locked VC is accepted (wr_ready unchanged) but discarded: no flit, remaining unchanged.
  - seq_err is set and stays 1 until reset.
- Undefined: wr_vc is ignored in BODY; seq_err is tied 0.

Test Plan:
- Single-flit packet: head data=0xA5A5_0001, vc=2, sz=0 -> one flit next cycle: new=1, last=1, vc_id=2, pkt_sz=0; busy stays 0.
- Four-flit packet: sz=3, vc=1, data 0x10..0x13, ready held 1 -> flits on 4 consecutive cycles; new=1 on the first only, last=1 on the fourth only, vc_id=1 and pkt_sz=3 on all four; busy 1 from the cycle after the head until the tail is accepted.
- Backpressure: sz=2 with pkt_out_ready=0 for 3 cycles after the head -> head flit held stable, wr_ready=0; after release all 3 flits are delivered in order with no loss or duplication.
- Back-to-back packets: sz=1 (vc0) immediately followed by sz=0 (vc2), continuous valid/ready -> 3 flits on 3 consecutive cycles with markers new, last, new+last; second packet vc_id=2.
- Reset mid-packet: sz=5, rst_axi_n=0 for one cycle after 2 body beats -> next cycle all outputs 0, state IDLE; the next beat is treated as a head with new=1.
- VC check (macro defined): sz=2 on vc1, second beat with wr_vc=0 -> beat dropped, seq_err=1; next two vc1 beats complete the packet, last=1 on the third emitted flit. With the macro undefined, the same stimulus emits 3 flits on vc1 and seq_err stays 0.
